spectrogram_write_ctrl: RTL and testbench

//  Write-side scheduler for the banked waterfall RAM read by the display path. Accepts one FFT

---
 rtl/spectro_pkg.sv | 33 +++
 rtl/spectro_addr_map.sv | 35 +++
 rtl/spectrogram_write_ctrl.sv | 130 +++++++++++++
 tb/tb_spectrogram_write_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spectro_pkg.sv
// Shared layout constants, FSM state type and linear-index -> {bank, addr} mapping
// for the waterfall RAM; the read-side mapper imports this so both sides agree on layout.
package spectro_pkg;
  localparam int FFT_SIZE       = 256;
  localparam int DATA_WIDTH     = 4;
  localparam int NO_FFTS        = 50;
  localparam int NO_BANKS       = 2;
  localparam int RAM_ADDR_WIDTH = 12;

  localparam int BINS      = FFT_SIZE / 2;
  localparam int BIN_W     = $clog2(BINS);
  localparam int SAMPLE_W  = $clog2(FFT_SIZE);
  localparam int IDX_WIDTH = $clog2(NO_FFTS);
  localparam int LIN_W     = $clog2(NO_BANKS * (2 ** RAM_ADDR_WIDTH));
  localparam int CLEAR_LEN = NO_FFTS * BINS;

  typedef enum logic [2:0] {CLEAR, IDLE, CAPTURE, DISCARD, COMMIT} state_t;

  typedef struct packed {
    logic [NO_BANKS-1:0]       bank;
    logic [RAM_ADDR_WIDTH-1:0] addr;
  } ram_loc_t;

  // Banks are stacked: the bits above the per-bank address select the bank.
  function automatic ram_loc_t lin_to_ram(input logic [LIN_W-1:0] lin);
    ram_loc_t loc;
    loc.addr = lin[RAM_ADDR_WIDTH-1:0];
    for (int b = 0; b < NO_BANKS; b++) begin
      loc.bank[b] = (int'(lin >> RAM_ADDR_WIDTH) == b);
    end
    return loc;
  endfunction
endpackage

// File: rtl/spectro_addr_map.sv
// Registers a write request: linear RAM index -> one-hot bank + per-bank address,
// giving the one-cycle write latency seen on the RAM port.
module spectro_addr_map
  import spectro_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req,
  input  logic [LIN_W-1:0]          lin,
  input  logic [DATA_WIDTH-1:0]     data,
  output logic                      wr_en,
  output logic [NO_BANKS-1:0]       wr_bank,
  output logic [RAM_ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data
);
  ram_loc_t loc;

  assign loc = lin_to_ram(lin);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_bank <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= req;
      if (req) begin
        wr_bank <= loc.bank;
        wr_addr <= loc.addr;
        wr_data <= data;
      end
    end
  end
endmodule

// File: rtl/spectrogram_write_ctrl.sv
// Waterfall RAM write scheduler: post-reset clear sweep, frame capture into the current row,
// row commit. Define SPECTRO_DROP_CNT_EN to add the drop_cnt output.
module spectrogram_write_ctrl
  import spectro_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      freeze,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic                      s_last,
  output logic                      wr_en,
  output logic [NO_BANKS-1:0]       wr_bank,
  output logic [RAM_ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [IDX_WIDTH-1:0]      oldest_fft_idx,
  output logic                      frame_err,
  output logic                      clear_done
`ifdef SPECTRO_DROP_CNT_EN
  ,
  output logic [15:0]               drop_cnt
`endif
);
  if (NO_FFTS * BINS > NO_BANKS * (2 ** RAM_ADDR_WIDTH)) begin : g_size_check
    $error("waterfall ring does not fit in the RAM banks");
  end

  state_t              state;
  logic [SAMPLE_W-1:0] sample_cnt;
  logic [LIN_W-1:0]    clear_idx;

  logic                  hs, capturing, is_final, frame_end, short_end, long_end, wr_req;
  logic [SAMPLE_W-1:0]   cur;
  logic [LIN_W-1:0]      wr_lin;
  logic [DATA_WIDTH-1:0] wr_val;

  // A sample transfers on a rising edge where s_valid and s_ready are both high; s_ready is
  // registered and depends only on state, never on s_valid.
  always_comb begin
    hs        = s_valid & s_ready;
    cur       = (state == IDLE) ? '0 : sample_cnt;
    capturing = (state == IDLE) ? !freeze : (state == CAPTURE);
    is_final  = (cur == SAMPLE_W'(FFT_SIZE - 1));
    frame_end = hs & (s_last | is_final);
    short_end = s_last & !is_final;
    long_end  = is_final & !s_last;
    wr_req    = 1'b0;
    wr_lin    = '0;
    wr_val    = '0;
    if (state == CLEAR) begin
      wr_req = 1'b1;
      wr_lin = clear_idx;
    end else if (hs && capturing && !cur[SAMPLE_W-1]) begin
      // Only the lower half (positive-frequency bins) is stored.
      wr_req = 1'b1;
      wr_lin = (LIN_W'(oldest_fft_idx) << BIN_W) + LIN_W'(cur[BIN_W-1:0]);
      wr_val = s_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= CLEAR;
      s_ready        <= 1'b0;
      oldest_fft_idx <= '0;
      frame_err      <= 1'b0;
      clear_done     <= 1'b0;
      sample_cnt     <= '0;
      clear_idx      <= '0;
`ifdef SPECTRO_DROP_CNT_EN
      drop_cnt       <= '0;
`endif
    end else begin
      frame_err <= 1'b0;
      case (state)
        CLEAR: begin
          if (clear_idx == LIN_W'(CLEAR_LEN - 1)) begin
            state      <= IDLE;
            clear_done <= 1'b1;
            s_ready    <= 1'b1;
          end else begin
            clear_idx <= clear_idx + LIN_W'(1);
          end
        end
        IDLE, CAPTURE, DISCARD: begin
          if (hs) begin
            if (frame_end) begin
              sample_cnt <= '0;
              frame_err  <= short_end | long_end;
              // An overlong frame still fills its row, so it is committed; a short one is not.
              if (capturing && !short_end) begin
                state   <= COMMIT;
                s_ready <= 1'b0;
              end else begin
                state <= IDLE;
              end
`ifdef SPECTRO_DROP_CNT_EN
              if ((!capturing || short_end || long_end) && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
`endif
            end else begin
              sample_cnt <= cur + SAMPLE_W'(1);
              state      <= capturing ? CAPTURE : DISCARD;
            end
          end
        end
        COMMIT: begin
          oldest_fft_idx <= (oldest_fft_idx == IDX_WIDTH'(NO_FFTS - 1)) ? '0
                                                                         : oldest_fft_idx + IDX_WIDTH'(1);
          state          <= IDLE;
          s_ready        <= 1'b1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  spectro_addr_map u_addr_map (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (wr_req),
    .lin     (wr_lin),
    .data    (wr_val),
    .wr_en   (wr_en),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );
endmodule

// File: tb/tb_spectrogram_write_ctrl.sv
// Scoreboard bench for spectrogram_write_ctrl: expected RAM writes are queued by the driver
// and popped by a monitor on every wr_en; control outputs are checked after each frame.
module tb_spectrogram_write_ctrl;
  localparam int W = 2 + 12 + 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        freeze = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [3:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [11:0] wr_addr;
  logic [3:0]  wr_data;
  logic [5:0]  oldest_fft_idx;
  logic        frame_err;
  logic        clear_done;
`ifdef SPECTRO_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int tests = 0;
  int failed = 0;
  int err_cycles = 0;
  int exp_err = 0;
  logic [W-1:0] exp_q[$];

  spectrogram_write_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .freeze         (freeze),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .wr_en          (wr_en),
    .wr_bank        (wr_bank),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .oldest_fft_idx (oldest_fft_idx),
    .frame_err      (frame_err),
    .clear_done     (clear_done)
`ifdef SPECTRO_DROP_CNT_EN
    ,
    .drop_cnt       (drop_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  function automatic logic [W-1:0] exp_word(input int row, input int bin, input logic [3:0] d);
    int lin;
    logic [1:0] bank;
    logic [11:0] addr;
    lin  = row * 128 + bin;
    bank = 2'(1 << (lin / 4096));
    addr = 12'(lin % 4096);
    return {bank, addr, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_en) begin
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_write: bank %0h addr %0h data %0h, none expected",
                   wr_bank, wr_addr, wr_data);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if ({wr_bank, wr_addr, wr_data} !== e) begin
            failed++;
            $display("FAIL write: got bank %0h addr %0h data %0h expected bank %0h addr %0h data %0h",
                     wr_bank, wr_addr, wr_data, e[17:16], e[15:4], e[3:0]);
          end
        end
      end
      if (frame_err) err_cycles++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sample(input logic [3:0] d, input logic last, input logic frz);
    int waitc;
    waitc   = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    freeze  = frz;
    while (!s_ready && waitc < 100) begin
      tick();
      waitc++;
    end
    if (!s_ready) begin
      tests++;
      failed++;
      $display("FAIL s_ready_timeout: got 0 expected 1 within 100 cycles");
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Sends n samples; last_at < 0 means no s_last; freeze=frz0 for samples below frz_until.
  task automatic send_frame(input int row, input int n, input int last_at,
                            input logic frz0, input int frz_until, input int seed);
    logic capture;
    logic frz;
    logic [3:0] d;
    capture = 1'b0;
    for (int i = 0; i < n; i++) begin
      frz = (i < frz_until) ? frz0 : 1'b0;
      d   = 4'((i + seed) & 15);
      if (i == 0) capture = !frz;
      if (capture && i < 128) exp_q.push_back(exp_word(row, i, d));
      drive_sample(d, i == last_at, frz);
    end
  endtask

  task automatic run_clear();
    int c;
    for (int i = 0; i < 6400; i++) exp_q.push_back(exp_word(0, i, 4'h0));
    c = 0;
    #3 reset_n = 1'b1;
    while (!clear_done && c < 7000) begin
      tick();
      c++;
    end
    check("clear_done", 32'(clear_done), 1);
    check("ready_after_clear", 32'(s_ready), 1);
    tick();
    check("clear_writes_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 0);
    check({tag, "_wr_en"}, 32'(wr_en), 0);
    check({tag, "_wr_bank_addr_data"}, 32'({wr_bank, wr_addr, wr_data}), 0);
    check({tag, "_oldest_idx"}, 32'(oldest_fft_idx), 0);
    check({tag, "_frame_err"}, 32'(frame_err), 0);
    check({tag, "_clear_done"}, 32'(clear_done), 0);
`ifdef SPECTRO_DROP_CNT_EN
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    run_clear();

    // Good frame into row 0, data = bin[3:0]; one dead cycle, then index advances.
    send_frame(0, 256, 255, 1'b0, 0, 0);
    check("f0_commit_ready_low", 32'(s_ready), 0);
    check("f0_idx_before_commit", 32'(oldest_fft_idx), 0);
    tick();
    check("f0_ready_back", 32'(s_ready), 1);
    check("f0_idx", 32'(oldest_fft_idx), 1);
    check("f0_no_err", 32'(err_cycles), 0);

    // 49 more good frames: index wraps 49 -> 0; row 33 lands in bank1 addr 128.
    for (int f = 1; f < 50; f++) begin
      send_frame(f, 256, 255, 1'b0, 0, f);
      check("ring_ready_low", 32'(s_ready), 0);
      tick();
      check("ring_idx", 32'(oldest_fft_idx), 32'((f + 1) % 50));
    end

    // Short frame: s_last at sample 100 -> error, no commit; next frame rewrites row 0.
    send_frame(0, 101, 100, 1'b0, 0, 7);
    exp_err++;
    check("short_err_pulse", 32'(frame_err), 1);
    check("short_no_commit_ready", 32'(s_ready), 1);
    tick();
    check("short_err_one_cycle", 32'(frame_err), 0);
    check("short_idx_unchanged", 32'(oldest_fft_idx), 0);
    send_frame(0, 256, 255, 1'b0, 0, 3);
    tick();
    check("rewrite_idx", 32'(oldest_fft_idx), 1);

    // Overlong frame: no s_last at sample 255 -> error but still committed.
    send_frame(1, 256, -1, 1'b0, 0, 9);
    exp_err++;
    check("long_err_pulse", 32'(frame_err), 1);
    check("long_commit_ready_low", 32'(s_ready), 0);
    tick();
    check("long_idx", 32'(oldest_fft_idx), 2);

    // Frozen at sample 0, freeze dropped at sample 10: discarded, no writes, no commit.
    send_frame(2, 256, 255, 1'b1, 10, 0);
    check("freeze_no_commit_ready", 32'(s_ready), 1);
    check("freeze_no_err", 32'(frame_err), 0);
    tick();
    check("freeze_idx_unchanged", 32'(oldest_fft_idx), 2);
`ifdef SPECTRO_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt), 3);
`endif
    check("writes_drained", 32'(exp_q.size()), 0);
    check("err_cycles", 32'(err_cycles), 32'(exp_err));

    // Reset in the middle of a frame (before sample 60 is accepted).
    send_frame(2, 60, -1, 1'b0, 0, 5);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    check("midreset_writes_drained", 32'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
    run_clear();
    check("post_reset_idx", 32'(oldest_fft_idx), 0);

    repeat (3) tick();
    check("final_queue_empty", 32'(exp_q.size()), 0);
    check("final_err_cycles", 32'(err_cycles), 32'(exp_err));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
